// File: rtl/conv1_pkg.sv
// conv1_pkg: state encoding and frame constants shared by the conv-1 frame sequencer
package conv1_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  localparam int IMG_PIXELS = 784;
  localparam int CONV1_OUTPUTS = 676;
  localparam int ADDR_W = 10;
endpackage

// File: rtl/conv1_pix_pipe.sv
// conv1_pix_pipe: aligns synchronous-read RAM data with its read enable, two-cycle read-to-pixel latency
module conv1_pix_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rd_en,
  input  logic [7:0] i_rd_data,
  output logic [7:0] o_pixel,
  output logic       o_valid
);
  logic       r_rd_d1;
  logic [7:0] r_pixel;
  logic       r_valid;
  always_ff @(posedge clk)
    if (rst) begin
      r_rd_d1 <= 1'b0;
      r_pixel <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rd_d1 <= i_rd_en;
      r_valid <= r_rd_d1;
      if (r_rd_d1) r_pixel <= i_rd_data;
    end
  assign o_pixel = r_pixel;
  assign o_valid = r_valid;
endmodule

// File: rtl/conv1_frame_ctrl.sv
// conv1_frame_ctrl: clears conv-1, streams one raster image from RAM into it and counts its outputs.
// Define CONV1_CTRL_WATCHDOG_EN to add the DRAIN idle watchdog and sticky err.
module conv1_frame_ctrl
  import conv1_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int HEIGHT = 28,
  parameter int K = 3
`ifdef CONV1_CTRL_WATCHDOG_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  output logic              conv_clr,
  input  logic              conv_valid_in,
  output logic              busy,
  output logic              done,
  output logic [9:0]        out_count,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [9:0] N_OUT = 10'((WIDTH - K + 1) * (HEIGHT - K + 1));
  state_t            r_state, w_next;
  logic              r_rd_en, r_clr, r_busy, r_done, w_timeout;
  logic [ADDR_W-1:0] r_addr;
  logic [9:0]        r_cnt, w_cnt_next;
  assign w_cnt_next = r_cnt + 10'((r_state == FEED || r_state == DRAIN) && conv_valid_in);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CLEAR : IDLE;
      CLEAR:   w_next = FEED;
      FEED:    w_next = (r_rd_en && r_addr == LAST) ? DRAIN : FEED;
      DRAIN:   w_next = (w_cnt_next >= N_OUT || w_timeout) ? DONE : DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each lines up with its state cycle.
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_clr   <= w_next == CLEAR;
      r_busy  <= w_next inside {CLEAR, FEED, DRAIN};
      r_done  <= w_next == DONE;
      r_rd_en <= w_next == FEED && !hold;
      r_cnt   <= (r_state == IDLE && start) ? '0 : w_cnt_next;
      if (r_state == IDLE && start) r_addr <= '0;
      else if (r_rd_en && r_addr != LAST) r_addr <= r_addr + 1'b1;
    end
`ifdef CONV1_CTRL_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] r_idle;
  logic          r_err;
  // Fires on the TIMEOUT-th consecutive strobe-free DRAIN cycle.
  assign w_timeout = r_state == DRAIN && !conv_valid_in && r_idle == IW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      r_idle <= '0;
      r_err  <= 1'b0;
    end else begin
      r_idle <= (r_state == DRAIN && !conv_valid_in) ? r_idle + 1'b1 : '0;
      r_err  <= (r_state == IDLE && start) ? 1'b0 : r_err | w_timeout;
    end
  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err = 1'b0;
`endif
  conv1_pix_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (r_rd_en),
    .i_rd_data (img_data),
    .o_pixel   (pixel_out),
    .o_valid   (pixel_valid)
  );
  assign img_rd_en = r_rd_en;
  assign img_addr  = r_addr;
  assign conv_clr  = r_clr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_count = r_cnt;
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// tb_conv1_frame_ctrl: scoreboard bench with a RAM model and a behavioural conv-1 strobe model
module tb_conv1_frame_ctrl;
  import conv1_pkg::*;
  logic clk = 0, rst = 1, start = 0, hold = 0, conv_valid_in = 0;
  logic [7:0] img_data = 0;
  logic img_rd_en, pixel_valid, conv_clr, busy, done, err;
  logic [9:0] img_addr, out_count;
  logic [7:0] pixel_out;

  conv1_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .conv_clr(conv_clr),
    .conv_valid_in(conv_valid_in), .busy(busy), .done(done),
    .out_count(out_count), .err(err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // RAM: data = addr[7:0], one-cycle read latency
  always @(posedge clk) if (img_rd_en) img_data <= img_addr[7:0];

  // conv-1 model: one output strobe per pixel whose 3x3 window is complete
  int pidx = 0, nstrobe = 0, lim = 1000;
  always @(posedge clk) begin
    if (rst || conv_clr) begin
      pidx <= 0; nstrobe <= 0; conv_valid_in <= 0;
    end else begin
      conv_valid_in <= 0;
      if (pixel_valid) begin
        pidx <= pidx + 1;
        if (pidx / 28 >= 2 && pidx % 28 >= 2 && nstrobe < lim) begin
          conv_valid_in <= 1; nstrobe <= nstrobe + 1;
        end
      end
    end
  end

  int addr_q[$], pix_q[$], cnt_q[$], err_q[$];
  int t0 = 0, t_clr, t_rd0, t_rdl, t_pv0, t_pvl, t_done, frz, gap, ndone;

  always @(negedge clk) begin
    if (!rst) begin
      if (conv_clr) begin
        t_clr = cyc - t0;
        chk("clr_out_count", out_count, 0);
      end
      if (img_rd_en) begin
        if (t_rd0 < 0) t_rd0 = cyc - t0;
        t_rdl = cyc - t0;
        if (addr_q.size() > 0) chk("img_addr", img_addr, addr_q.pop_front());
        else begin checks++; errors++; $display("FAIL img_addr: unexpected read at %0d", img_addr); end
      end
      if (!img_rd_en && busy && img_addr == 98) frz++;
      if (pixel_valid) begin
        if (t_pv0 < 0) t_pv0 = cyc - t0;
        else if (cyc - t0 - t_pvl - 1 > gap) gap = cyc - t0 - t_pvl - 1;
        t_pvl = cyc - t0;
        if (pix_q.size() > 0) chk("pixel_out", pixel_out, pix_q.pop_front());
        else begin checks++; errors++; $display("FAIL pixel_out: unexpected pixel %0d", pixel_out); end
      end
      if (done) begin
        ndone++;
        t_done = cyc - t0;
        if (cnt_q.size() > 0) begin
          chk("done_out_count", out_count, cnt_q.pop_front());
          chk("done_err", err, err_q.pop_front());
        end else begin checks++; errors++; $display("FAIL done: unexpected pulse, out_count %0d", out_count); end
      end
    end
  end

  task automatic begin_frame(int exp_cnt, int exp_err);
    for (int a = 0; a < IMG_PIXELS; a++) begin
      addr_q.push_back(a);
      pix_q.push_back(a % 256);
    end
    cnt_q.push_back(exp_cnt);
    err_q.push_back(exp_err);
    t_clr = -1; t_rd0 = -1; t_rdl = -1; t_pv0 = -1; t_pvl = -1; t_done = -1;
    frz = 0; gap = 0; ndone = 0;
    t0 = cyc; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic go_to(int c);
    while (cyc < t0 + c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (ndone == 0 && n < budget) begin @(posedge clk); n++; end
    #1;
    checks++;
    if (ndone == 0) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
  endtask

  task automatic flush();
    addr_q.delete(); pix_q.delete(); cnt_q.delete(); err_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {img_rd_en, img_addr, pixel_out, pixel_valid, conv_clr, busy, done, out_count, err}, 0);
    rst = 0;
    @(posedge clk); #1;

    // nominal frame
    begin_frame(CONV1_OUTPUTS, 0);
    go_to(500);
    chk("busy_mid", busy, 1);
    wait_done(2000);
    chk("nom_t_clr", t_clr, 1);
    chk("nom_t_rd0", t_rd0, 2);
    chk("nom_t_rdl", t_rdl, 785);
    chk("nom_t_pv0", t_pv0, 4);
    chk("nom_t_pvl", t_pvl, 787);
    chk("nom_t_done", t_done, 789);
    chk("nom_addr_last", img_addr, 783);
    chk("nom_left", addr_q.size() + pix_q.size() + cnt_q.size(), 0);
    repeat (5) @(posedge clk); #1;
    chk("nom_single_done", ndone, 1);
    chk("nom_idle_busy", busy, 0);
    chk("nom_hold_count", out_count, CONV1_OUTPUTS);

    // hold applied so reads pause in cycles 100..109 with img_addr parked at 98
    begin_frame(CONV1_OUTPUTS, 0);
    go_to(99); hold = 1;
    go_to(109); hold = 0;
    wait_done(2000);
    chk("hold_frozen_cycles", frz, 10);
    chk("hold_pv_gap", gap, 10);
    chk("hold_t_done", t_done, 799);

    // start while busy is ignored
    begin_frame(CONV1_OUTPUTS, 0);
    go_to(300); start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(2000);
    repeat (5) @(posedge clk); #1;
    chk("busy_start_t_done", t_done, 789);
    chk("busy_start_ndone", ndone, 1);

    // second start after DONE restarts the count
    begin_frame(CONV1_OUTPUTS, 0);
    go_to(3);
    chk("restart_count", out_count, 0);
    wait_done(2000);
    chk("restart_t_clr", t_clr, 1);
    chk("restart_t_done", t_done, 789);

    // reset mid-frame
    begin_frame(CONV1_OUTPUTS, 0);
    go_to(400); rst = 1;
    @(posedge clk); #1;
    chk("midrst_outputs", {img_rd_en, img_addr, pixel_out, pixel_valid, conv_clr, busy, done, out_count, err}, 0);
    rst = 0; flush();
    @(posedge clk); #1;
    begin_frame(CONV1_OUTPUTS, 0);
    wait_done(2000);
    chk("midrst_t_done", t_done, 789);
    chk("midrst_count", out_count, CONV1_OUTPUTS);

    // conv-1 stalls after 600 outputs
    lim = 600;
`ifdef CONV1_CTRL_WATCHDOG_EN
    begin_frame(600, 1);
    wait_done(2000);
    chk("wd_t_done", t_done, 850);
    chk("wd_err", err, 1);
    chk("wd_count", out_count, 600);
`else
    begin_frame(600, 0);
    go_to(1200);
    chk("nowd_busy", busy, 1);
    chk("nowd_ndone", ndone, 0);
    chk("nowd_count", out_count, 600);
    chk("nowd_err", err, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    flush();
`endif
    lim = 1000;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
